cci_target: RTL and testbench

// - I2C/CCI target (responder) with 16-bit register index and 8-bit data.
// - The counterpart to the camera-controller I2C initiator. Used as a sensor model in

---
 rtl/cci_pkg.sv | 22 ++
 rtl/cci_target_if.sv | 22 ++
 rtl/i2c_line_filter.sv | 52 +++++
 rtl/cci_target.sv | 173 +++++++++++++++++
 tb/tb_cci_target.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cci_pkg.sv
// Shared types and widths for the CCI target and its local register bus.
package cci_pkg;

    localparam int CCI_INDEX_WIDTH = 16;
    localparam int CCI_DATA_WIDTH  = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_IDX_HI,
        ST_IDX_HI_ACK,
        ST_IDX_LO,
        ST_IDX_LO_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } cci_target_state_t;

endpackage

// File: rtl/cci_target_if.sv
// Local register bus between the CCI target (master) and the register file (slave).
interface cci_target_if;
    import cci_pkg::*;

    logic [CCI_INDEX_WIDTH-1:0] reg_addr;
    logic                       reg_wr_en;
    logic [CCI_DATA_WIDTH-1:0]  reg_wr_data;
    logic                       reg_rd_en;
    logic [CCI_DATA_WIDTH-1:0]  reg_rd_data;
    logic                       busy;

    modport master (
        output reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy,
        input  reg_rd_data
    );

    modport slave (
        input  reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy,
        output reg_rd_data
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a stability filter for one I2C line; emits the
// accepted level and single-cycle rise/fall pulses aligned with level changes.
module i2c_line_filter #(
    parameter int FILTER_DEPTH = 3
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_accept;

    // A new level is taken once it has differed for FILTER_DEPTH consecutive cycles.
    assign w_accept = (r_sync[1] != r_level) && (int'(r_cnt) == FILTER_DEPTH - 1);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= w_accept & r_sync[1];
            r_fall <= w_accept & ~r_sync[1];
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/cci_target.sv
// I2C/CCI target: 16-bit register index, 8-bit data, auto-incrementing bursts,
// open-drain SDA, never stretches SCL.
module cci_target
    import cci_pkg::*;
#(
    parameter logic [7:0] ADDRESS      = 8'h20,
    parameter int         FILTER_DEPTH = 3
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         scl,
    inout  wire          sda,
    cci_target_if.master rb
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_rx_state;

    cci_target_state_t r_state, w_state_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic [7:0]  r_shift, r_idx_hi, r_wr_data, w_byte;
    logic [15:0] r_reg_addr;
    logic        r_rw, r_sda_low, w_sda_low_nxt, r_busy;
    logic        r_wr_en, r_rd_en, r_rd_q;
    logic        w_wr_stb, w_rd_stb, w_hi_ld, w_idx_ld, w_rd_inc, w_rw_ld;
    logic        w_busy_set, w_busy_clr;

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl (
        .clk_in(clk_in), .reset_n(reset_n), .i_line(scl),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda (
        .clk_in(clk_in), .reset_n(reset_n), .i_line(sda),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_rx_state = (r_state == ST_ADDR) || (r_state == ST_IDX_HI) || (r_state == ST_IDX_LO)
                     || (r_state == ST_WDATA) || (r_state == ST_RDATA);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= '0;
            r_sda_low  <= 1'b0;
            r_shift    <= '0;
            r_idx_hi   <= '0;
            r_rw       <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_q     <= 1'b0;
            r_reg_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_wr_en   <= w_wr_stb;
            r_rd_en   <= w_rd_stb;
            r_rd_q    <= r_rd_en;
            if (w_wr_stb) r_wr_data <= w_byte;
            if (w_hi_ld)  r_idx_hi  <= w_byte;
            if (w_rw_ld)  r_rw      <= w_byte[0];
            // Read data arrives the cycle after the request and replaces the shifter.
            if (r_rd_q)
                r_shift <= rb.reg_rd_data;
            else if (w_scl_rise && w_rx_state)
                r_shift <= w_byte;
            if (w_idx_ld)
                r_reg_addr <= {r_idx_hi, w_byte};
            else if (r_wr_en || w_rd_inc)
                r_reg_addr <= r_reg_addr + 16'd1;
            if (w_busy_clr)
                r_busy <= 1'b0;
            else if (w_busy_set)
                r_busy <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bitcnt_nxt  = r_bitcnt;
        w_sda_low_nxt = r_sda_low;
        w_wr_stb      = 1'b0;
        w_rd_stb      = 1'b0;
        w_hi_ld       = 1'b0;
        w_idx_ld      = 1'b0;
        w_rd_inc      = 1'b0;
        w_rw_ld       = 1'b0;
        w_busy_set    = 1'b0;
        w_busy_clr    = 1'b0;
        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bitcnt_nxt  = '0;
            w_sda_low_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bitcnt_nxt  = '0;
            w_sda_low_nxt = 1'b0;
            w_busy_clr    = 1'b1;
        end else if (w_rx_state) begin
            if (w_scl_fall) w_sda_low_nxt = (r_state == ST_RDATA) && !r_shift[7];
            if (w_scl_rise) begin
                w_bitcnt_nxt = r_bitcnt + 4'd1;
                if (r_bitcnt == 4'd7) begin
                    case (r_state)
                        ST_ADDR: begin
                            if (w_byte[7:1] == ADDRESS[7:1]) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_busy_set  = 1'b1;
                                w_rw_ld     = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                                w_busy_clr  = 1'b1;
                            end
                        end
                        ST_IDX_HI: begin w_state_nxt = ST_IDX_HI_ACK; w_hi_ld  = 1'b1; end
                        ST_IDX_LO: begin w_state_nxt = ST_IDX_LO_ACK; w_idx_ld = 1'b1; end
                        ST_WDATA:  begin w_state_nxt = ST_WDATA_ACK;  w_wr_stb = 1'b1; end
                        default:   w_state_nxt = ST_RDATA_ACK;
                    endcase
                end
            end
        end else begin
            case (r_state)
                ST_ADDR_ACK, ST_IDX_HI_ACK, ST_IDX_LO_ACK, ST_WDATA_ACK, ST_RDATA_ACK: begin
                    // 8th fall starts our ACK (or releases for the initiator's ACK);
                    // the 9th rise moves on, and the next fall releases via the data state.
                    if (w_scl_fall) w_sda_low_nxt = (r_state != ST_RDATA_ACK);
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = '0;
                        case (r_state)
                            ST_ADDR_ACK: begin
                                if (r_rw) begin
                                    w_state_nxt = ST_RDATA;
                                    w_rd_stb    = 1'b1;
                                end else begin
                                    w_state_nxt = ST_IDX_HI;
                                end
                            end
                            ST_IDX_HI_ACK: w_state_nxt = ST_IDX_LO;
                            ST_IDX_LO_ACK, ST_WDATA_ACK: w_state_nxt = ST_WDATA;
                            default: begin
                                w_rd_inc = 1'b1;
                                if (!w_sda) begin
                                    w_state_nxt = ST_RDATA;
                                    w_rd_stb    = 1'b1;
                                end else begin
                                    w_state_nxt = ST_IGNORE;
                                    w_busy_clr  = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: w_sda_low_nxt = 1'b0;
            endcase
        end
    end

    assign sda            = r_sda_low ? 1'b0 : 1'bz;
    assign rb.reg_addr    = r_reg_addr;
    assign rb.reg_wr_en   = r_wr_en;
    assign rb.reg_wr_data = r_wr_data;
    assign rb.reg_rd_en   = r_rd_en;
    assign rb.busy        = r_busy;

endmodule

// File: tb/tb_cci_target.sv
// Directed bench: task-based I2C initiator, register model, strobe scoreboard.
module tb_cci_target;

    localparam int Q = 15;  // quarter SCL period in clk_in cycles (~400 kHz at 24 MHz)

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk_in    = 1'b0;
    logic reset_n   = 1'b0;
    logic m_scl     = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    int checks   = 0;
    int failures = 0;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    cci_target_if rb();

    cci_target #(.ADDRESS(8'h40), .FILTER_DEPTH(3)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .scl     (m_scl),
        .sda     (sda),
        .rb      (rb)
    );

    always #21 clk_in = ~clk_in;

    // Register model: data = low index byte + 2, valid the cycle after the request.
    always_ff @(posedge clk_in)
        if (rb.reg_rd_en) rb.reg_rd_data <= rb.reg_addr[7:0] + 8'h02;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        wr_t         e;
        logic [15:0] a;
        if (reset_n && (rb.reg_wr_en || rb.reg_rd_en)) begin
            chk("wr_rd_exclusive", {31'd0, rb.reg_wr_en & rb.reg_rd_en}, 32'd0);
            if (rb.reg_wr_en) begin
                chk("wr_strobe_expected", {31'd0, wr_q.size() != 0}, 32'd1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    chk("wr_strobe_addr_data", {8'd0, rb.reg_addr, rb.reg_wr_data}, {8'd0, e});
                end
            end
            if (rb.reg_rd_en) begin
                chk("rd_strobe_expected", {31'd0, rd_q.size() != 0}, 32'd1);
                if (rd_q.size() != 0) begin
                    a = rd_q.pop_front();
                    chk("rd_strobe_addr", {16'd0, rb.reg_addr}, {16'd0, a});
                end
            end
        end
    end

    task automatic q();
        repeat (Q) @(negedge clk_in);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; q();
        m_scl = 1'b1;     q();
        m_sda_low = 1'b1; q();
        m_scl = 1'b0;     q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; q();
        m_scl = 1'b1;     q();
        m_sda_low = 1'b0; q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda_low = ~b[i]; q();
            m_scl = 1'b1;      q(); q();
            m_scl = 1'b0;      q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda_low = 1'b0; q();
        m_scl = 1'b1;     q();
        ack = sda;        q();
        m_scl = 1'b0;     q();
    endtask

    task automatic wb(input logic [7:0] b, input string tag);
        logic ack;
        write_byte(b, ack);
        chk(tag, {31'd0, ack}, 32'd0);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            q();
            m_scl = 1'b1; q();
            b[i] = sda;   q();
            m_scl = 1'b0;
        end
        q();
        m_sda_low = ~nack; q();
        m_scl = 1'b1;      q(); q();
        m_scl = 1'b0;      q();
        m_sda_low = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       ack;
        logic       seen;

        // Reset state
        repeat (5) @(negedge clk_in);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        chk("rst_busy", {31'd0, rb.busy}, 32'd0);
        chk("rst_reg_addr", {16'd0, rb.reg_addr}, 32'd0);
        chk("rst_wr_en", {31'd0, rb.reg_wr_en}, 32'd0);
        chk("rst_rd_en", {31'd0, rb.reg_rd_en}, 32'd0);
        reset_n = 1'b1;
        q();

        // Single write 0100 = 01
        wr_q.push_back('{16'h0100, 8'h01});
        bus_start();
        wb(8'h40, "w_addr_ack");
        chk("w_busy_set", {31'd0, rb.busy}, 32'd1);
        wb(8'h01, "w_idxhi_ack");
        wb(8'h00, "w_idxlo_ack");
        wb(8'h01, "w_data_ack");
        bus_stop(); q();
        chk("w_busy_clr", {31'd0, rb.busy}, 32'd0);
        chk("w_all_strobes", wr_q.size(), 32'd0);
        chk("w_addr_after", {16'd0, rb.reg_addr}, 32'h0101);

        // Repeated-START read of 0000, NACK
        rd_q.push_back(16'h0000);
        bus_start();
        wb(8'h40, "r_addr_ack");
        wb(8'h00, "r_idxhi_ack");
        wb(8'h00, "r_idxlo_ack");
        bus_start();
        wb(8'h41, "r_raddr_ack");
        read_byte(d, 1'b1);
        chk("r_data", {24'd0, d}, 32'h02);
        bus_stop(); q();
        chk("r_all_strobes", rd_q.size(), 32'd0);
        chk("r_addr_after", {16'd0, rb.reg_addr}, 32'h0001);
        chk("r_busy_clr", {31'd0, rb.busy}, 32'd0);

        // Two-byte read burst from 0010
        rd_q.push_back(16'h0010);
        rd_q.push_back(16'h0011);
        bus_start();
        wb(8'h40, "rb_addr_ack");
        wb(8'h00, "rb_idxhi_ack");
        wb(8'h10, "rb_idxlo_ack");
        bus_start();
        wb(8'h41, "rb_raddr_ack");
        read_byte(d, 1'b0);
        chk("rb_data0", {24'd0, d}, 32'h12);
        read_byte(d, 1'b1);
        chk("rb_data1", {24'd0, d}, 32'h13);
        bus_stop(); q();
        chk("rb_all_strobes", rd_q.size(), 32'd0);
        chk("rb_addr_after", {16'd0, rb.reg_addr}, 32'h0012);

        // Address mismatch, then a matching repeated START
        bus_start();
        write_byte(8'h42, ack);
        chk("mm_addr_nack", {31'd0, ack}, 32'd1);
        chk("mm_busy", {31'd0, rb.busy}, 32'd0);
        write_byte(8'h01, ack);
        chk("mm_byte_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h00, ack);
        chk("mm_busy_still", {31'd0, rb.busy}, 32'd0);
        wr_q.push_back('{16'h0005, 8'h5A});
        bus_start();
        wb(8'h40, "mm_addr2_ack");
        chk("mm_busy_after_ack", {31'd0, rb.busy}, 32'd1);
        wb(8'h00, "mm_idxhi_ack");
        wb(8'h05, "mm_idxlo_ack");
        wb(8'h5A, "mm_data_ack");
        bus_stop(); q();
        chk("mm_all_strobes", wr_q.size(), 32'd0);

        // Burst write wrapping at FFFF
        wr_q.push_back('{16'hFFFF, 8'hAA});
        wr_q.push_back('{16'h0000, 8'hBB});
        bus_start();
        wb(8'h40, "wrap_addr_ack");
        wb(8'hFF, "wrap_idxhi_ack");
        wb(8'hFF, "wrap_idxlo_ack");
        wb(8'hAA, "wrap_d0_ack");
        wb(8'hBB, "wrap_d1_ack");
        bus_stop(); q();
        chk("wrap_all_strobes", wr_q.size(), 32'd0);
        chk("wrap_addr_after", {16'd0, rb.reg_addr}, 32'h0001);

        // Partial data byte cut by STOP: no write
        bus_start();
        wb(8'h40, "part_addr_ack");
        wb(8'h00, "part_idxhi_ack");
        wb(8'h20, "part_idxlo_ack");
        send_bits(8'hC0, 4);
        bus_stop(); q();
        chk("part_addr_after", {16'd0, rb.reg_addr}, 32'h0020);
        chk("part_busy", {31'd0, rb.busy}, 32'd0);

        // One-cycle SCL glitch while idle must be filtered out
        seen = 1'b0;
        @(negedge clk_in) m_scl = 1'b0;
        @(negedge clk_in) m_scl = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            seen = seen | ~dut.w_scl;
        end
        chk("glitch_filtered", {31'd0, seen}, 32'd0);
        chk("glitch_busy", {31'd0, rb.busy}, 32'd0);
        wr_q.push_back('{16'h0030, 8'hC3});
        bus_start();
        wb(8'h40, "gl_addr_ack");
        wb(8'h00, "gl_idxhi_ack");
        wb(8'h30, "gl_idxlo_ack");
        wb(8'hC3, "gl_data_ack");
        bus_stop(); q();
        chk("gl_all_strobes", wr_q.size(), 32'd0);

        // Asynchronous reset while the target is driving ACK
        bus_start();
        send_bits(8'h40, 8);
        m_sda_low = 1'b0; q();
        chk("rst_ack_driven", {31'd0, sda}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_sda_released", {31'd0, sda}, 32'd1);
        chk("rst_busy_mid", {31'd0, rb.busy}, 32'd0);
        chk("rst_addr_mid", {16'd0, rb.reg_addr}, 32'd0);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        q();
        bus_stop(); q();
        wr_q.push_back('{16'h0102, 8'h7E});
        bus_start();
        wb(8'h40, "post_addr_ack");
        wb(8'h01, "post_idxhi_ack");
        wb(8'h02, "post_idxlo_ack");
        wb(8'h7E, "post_data_ack");
        bus_stop(); q();
        chk("post_all_strobes", wr_q.size(), 32'd0);
        chk("post_addr_after", {16'd0, rb.reg_addr}, 32'h0103);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
